// File: rtl/riscv_pkg.sv
// Shared core types: memory-arbiter FSM states, bus owner and byte-enable constant.
package riscv_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
   typedef enum logic {ARB_OWN_DATA, ARB_OWN_FETCH} arb_owner_e;

   // Wide enough for any practical DATA_W; users slice the low DATA_W/8 bits.
   localparam int ARB_BE_MAX_W = 128;
   localparam logic [ARB_BE_MAX_W-1:0] ARB_BE_FULL = '1;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Single-bus arbiter between instruction fetch and load/store ports: data wins by
// default, a saturating starvation counter forces fetch after STARVE_MAX data wins.
module riscv_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_valid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_valid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                spurious_rsp
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   arb_state_e       state;
   arb_owner_e       owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             pick_fetch;
   logic             rsp_take;

   assign pick_fetch = if_req && (!d_req || starve_cnt == CNT_MAX);
   assign rsp_take   = mem_rvalid && ((state == ARB_ISSUE && mem_gnt) || state == ARB_WAIT);
   assign mem_req    = (state == ARB_ISSUE);
   assign stall_if   = if_req && !if_valid;
   assign stall_mem  = d_req && !d_valid;

   // The issue registers double as the bus fields; they only change in IDLE,
   // so they stay stable for the whole ISSUE phase however long gnt takes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         owner        <= ARB_OWN_DATA;
         starve_cnt   <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_be       <= '0;
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         if_rdata     <= '0;
         d_rdata      <= '0;
         spurious_rsp <= 1'b0;
      end else begin
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         spurious_rsp <= mem_rvalid && (state == ARB_IDLE || state == ARB_RESP);
         case (state)
            ARB_IDLE: begin
               if (if_req || d_req) begin
                  state <= ARB_ISSUE;
                  if (pick_fetch) begin
                     owner      <= ARB_OWN_FETCH;
                     starve_cnt <= '0;
                     mem_we     <= 1'b0;
                     mem_addr   <= if_addr & ~ADDR_W'(3);
                     mem_wdata  <= '0;
                     mem_be     <= ARB_BE_FULL[BE_W-1:0];
                  end else begin
                     owner <= ARB_OWN_DATA;
                     if (!if_req)
                        starve_cnt <= '0;
                     else if (starve_cnt != CNT_MAX)
                        starve_cnt <= starve_cnt + CNT_W'(1);
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_be    <= d_be;
                  end
               end
            end
            ARB_ISSUE: if (mem_gnt) state <= mem_rvalid ? ARB_RESP : ARB_WAIT;
            ARB_WAIT:  if (mem_rvalid) state <= ARB_RESP;
            ARB_RESP:  state <= ARB_IDLE;
            default:   state <= ARB_IDLE;
         endcase
         // Captured on entry to RESP so the valid pulse lines up with the RESP cycle.
         if (rsp_take) begin
            if (owner == ARB_OWN_FETCH) begin
               if_rdata <= mem_rdata;
               if_valid <= 1'b1;
            end else begin
               d_rdata <= mem_we ? '0 : mem_rdata;
               d_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed + randomized bench for riscv_mem_arbiter against a word-memory scoreboard.
module tb_riscv_mem_arbiter;

   localparam int ADDR_W = 32, DATA_W = 32, STARVE_MAX = 4, BE_W = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic if_req, if_valid, d_req, d_we, d_valid;
   logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
   logic [DATA_W-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
   logic [BE_W-1:0]   d_be, mem_be;
   logic mem_req, mem_we, mem_gnt, mem_rvalid, stall_if, stall_mem, spurious_rsp;

   riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .spurious_rsp(spurious_rsp));

   initial forever #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int idx);
      return 32'h1000_0000 + 32'(idx) * 32'h101;
   endfunction

   // Bus-side memory model
   logic [31:0] bus_mem [int];
   bit rnd_mode = 0, ovr_en = 0, ovr_gnt = 0, ovr_rvalid = 0;
   logic [31:0] ovr_rdata = '0;
   int gnt_delay = 0, rsp_delay = 1;

   function automatic logic [31:0] bus_rd(input int idx);
      return bus_mem.exists(idx) ? bus_mem[idx] : init_word(idx);
   endfunction

   initial begin
      int gwait, rwait, rd, idx;
      bit pend;
      logic [31:0] pdata, w;
      gwait = 0; rwait = 0; pend = 0; pdata = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_gnt = 0; mem_rvalid = 0;
         if (ovr_en) begin
            mem_gnt = ovr_gnt; mem_rvalid = ovr_rvalid; mem_rdata = ovr_rdata;
            pend = 0; gwait = 0;
         end else if (pend) begin
            if (rwait == 0) begin mem_rvalid = 1; mem_rdata = pdata; pend = 0; end
            else rwait--;
         end else if (mem_req) begin
            if (gwait >= gnt_delay) begin
               mem_gnt = 1; gwait = 0;
               idx = int'(mem_addr >> 2);
               if (mem_we) begin
                  w = bus_rd(idx);
                  for (int b = 0; b < BE_W; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                  bus_mem[idx] = w;
                  pdata = 32'hBAD0_0000 | 32'(idx);  // junk the arbiter must not forward
               end else pdata = bus_rd(idx);
               if (rnd_mode) begin gnt_delay = $urandom_range(0, 3); rd = $urandom_range(0, 2); end
               else rd = rsp_delay;
               if (rd == 0) begin mem_rvalid = 1; mem_rdata = pdata; end
               else begin pend = 1; rwait = rd - 1; end
            end else gwait++;
         end
      end
   end

   // Protocol monitor: fields stable while waiting for gnt, never two valids at once
   initial begin
      bit hold;
      logic [127:0] prev;
      hold = 0; prev = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) hold = 0;
         else begin
            if (hold) begin
               chk("hold_req", mem_req, 1);
               chk("hold_fields", {mem_we, mem_addr, mem_wdata, mem_be}, prev);
            end
            chk("one_valid", if_valid & d_valid, 0);
            hold = mem_req && !mem_gnt;
            prev = {mem_we, mem_addr, mem_wdata, mem_be};
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Scoreboard memory
   logic [31:0] ref_mem [int];
   function automatic logic [31:0] ref_rd(input int idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
   endfunction

   task automatic tick; @(posedge clk); #1; endtask

   task automatic wait_pulse(input bit fetch, input int budget, input string tag);
      int n;
      n = 0;
      while (!(fetch ? if_valid : d_valid) && n < budget) begin tick(); n++; end
      if (n >= budget) chk(tag, n, 0);
   endtask

   initial begin
      int ndata, vcnt, spcnt;
      bit fetch_seen, early_if;
      bit if_pend, d_pend, if_just, d_just;
      int if_age, d_age, dwins;
      logic [31:0] w;
      if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;

      // Reset state
      rst_n = 0; tick(); tick();
      chk("rst_mem_req", mem_req, 0); chk("rst_if_valid", if_valid, 0);
      chk("rst_d_valid", d_valid, 0); chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0); chk("rst_spurious", spurious_rsp, 0);
      chk("rst_fields", {mem_we, mem_addr, mem_wdata, mem_be}, 0);
      rst_n = 1; tick();

      // Fetch only, gnt at N+1, rvalid at N+2
      bus_mem[32'h1004 >> 2] = 32'h0000_0013;
      if_addr = 32'h0000_1006; if_req = 1; #1;
      chk("f_stall_n", stall_if, 1);
      tick();
      chk("f_mem_req", mem_req, 1); chk("f_mem_addr", mem_addr, 32'h1004);
      chk("f_mem_we", mem_we, 0); chk("f_mem_be", mem_be, 4'hF);
      chk("f_stall_n1", stall_if, 1); chk("f_valid_n1", if_valid, 0);
      tick();
      chk("f_req_wait", mem_req, 0); chk("f_stall_n2", stall_if, 1); chk("f_valid_n2", if_valid, 0);
      tick();
      chk("f_valid_n3", if_valid, 1); chk("f_rdata", if_rdata, 32'h13); chk("f_stall_n3", stall_if, 0);
      if_req = 0; tick();
      chk("f_valid_once", if_valid, 0);

      // Simultaneous fetch + load: data first
      bus_mem[32'h2000 >> 2] = 32'hCAFE_F00D;
      if_addr = 32'h100; if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
      tick();
      chk("s_first_addr", mem_addr, 32'h2000); chk("s_first_we", mem_we, 0);
      early_if = 0;
      for (int n = 0; n < 20 && !d_valid; n++) begin tick(); if (if_valid) early_if = 1; end
      chk("s_d_valid", d_valid, 1); chk("s_if_not_first", early_if, 0);
      chk("s_d_rdata", d_rdata, 32'hCAFE_F00D);
      d_req = 0; tick(); tick();
      chk("s_fetch_req", mem_req, 1); chk("s_fetch_addr", mem_addr, 32'h100);
      wait_pulse(1, 20, "s_fetch_timeout");
      chk("s_if_rdata", if_rdata, init_word(32'h100 >> 2));
      if_req = 0; tick();

      // Starvation: back-to-back stores with fetch pending, twice
      d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h5555_AAAA; d_be = 4'hF;
      if_addr = 32'h200; if_req = 1;
      for (int p = 0; p < 2; p++) begin
         ndata = 0; fetch_seen = 0;
         for (int n = 0, pr = 0; n < 200; n++) begin
            pr = mem_req;
            tick();
            if (mem_req && !pr) begin if (mem_we) ndata++; else fetch_seen = 1; end
            if (if_valid) break;
         end
         chk("starve_data_grants", ndata, STARVE_MAX);
         chk("starve_fetch_grant", fetch_seen, 1);
         chk("starve_if_valid", if_valid, 1);
         if_req = 0; tick();
         wait_pulse(0, 30, "starve_store_timeout");
         if (p == 0) if_req = 1;
      end
      d_req = 0; tick(); tick();

      // Gnt delayed 3 cycles
      gnt_delay = 3;
      bus_mem[32'h3000 >> 2] = 32'h1234_5678;
      d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("g_req_held", mem_req, 1); chk("g_addr_held", mem_addr, 32'h3000);
      end
      tick();
      chk("g_req_drop", mem_req, 0);
      vcnt = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (d_valid) begin vcnt++; chk("g_rdata", d_rdata, 32'h1234_5678); d_req = 0; end
      end
      chk("g_one_completion", vcnt, 1);
      gnt_delay = 0;

      // Same-cycle gnt+rvalid on a partial store
      rsp_delay = 0;
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
      tick();
      chk("w_mem_be", mem_be, 4'h3); chk("w_mem_we", mem_we, 1); chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      chk("w_d_valid", d_valid, 1); chk("w_d_rdata", d_rdata, 0);
      d_req = 0; tick();
      chk("w_valid_once", d_valid, 0);
      rsp_delay = 1;

      // Reset in WAIT, then a late rvalid
      ovr_en = 1; ovr_gnt = 0; ovr_rvalid = 0; ovr_rdata = 32'h77;
      if_addr = 32'h80; if_req = 1;
      tick(); chk("r_issue", mem_req, 1); ovr_gnt = 1;
      tick(); ovr_gnt = 0; chk("r_wait", mem_req, 0);
      rst_n = 0; if_req = 0; #1;
      chk("r_outs_zero", {mem_req, if_valid, d_valid, spurious_rsp, stall_if, stall_mem}, 0);
      chk("r_rdata_zero", {if_rdata, d_rdata}, 0);
      tick(); tick(); rst_n = 1;
      tick(); tick(); ovr_rvalid = 1;
      tick(); ovr_rvalid = 0;
      chk("r_spurious", spurious_rsp, 1);
      spcnt = 0; vcnt = 0;
      for (int n = 0; n < 5; n++) begin tick(); spcnt += spurious_rsp; vcnt += if_valid + d_valid; end
      chk("r_spurious_once", spcnt, 0); chk("r_no_valid", vcnt, 0);
      chk("r_if_rdata", if_rdata, 0);
      ovr_en = 0;

      // Randomized traffic against the scoreboard
      bus_mem.delete(); rnd_mode = 1;
      if_pend = 0; d_pend = 0; if_just = 0; d_just = 0; if_age = 0; d_age = 0; dwins = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         tick();
         chk("rnd_stall_if", stall_if, if_req && !if_valid);
         chk("rnd_stall_mem", stall_mem, d_req && !d_valid);
         if_just = if_valid; d_just = d_valid;
         if (if_valid) begin
            chk("rnd_if_pending", if_pend, 1);
            chk("rnd_if_rdata", if_rdata, ref_rd(int'(if_addr >> 2)));
            if_pend = 0; if_req = 0;
         end
         if (d_valid) begin
            chk("rnd_d_pending", d_pend, 1);
            if (d_we) begin
               chk("rnd_store_rdata", d_rdata, 0);
               w = ref_rd(int'(d_addr >> 2));
               for (int b = 0; b < BE_W; b++) if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
               ref_mem[int'(d_addr >> 2)] = w;
            end else chk("rnd_load_rdata", d_rdata, ref_rd(int'(d_addr >> 2)));
            // one in-flight data transaction may predate the fetch request
            if (if_pend) begin dwins++; chk("rnd_starve_bound", dwins <= STARVE_MAX + 1, 1); end
            d_pend = 0; d_req = 0;
         end
         if (if_pend && ++if_age > 200) begin chk("rnd_if_timeout", if_age, 0); if_pend = 0; if_req = 0; end
         if (d_pend && ++d_age > 200) begin chk("rnd_d_timeout", d_age, 0); d_pend = 0; d_req = 0; end
         if (cyc < 1900 && !if_pend && !if_just && $urandom_range(0, 2) == 0) begin
            if_addr = 32'($urandom_range(0, 63)); if_req = 1; if_pend = 1; if_age = 0; dwins = 0;
         end
         if (cyc < 1900 && !d_pend && !d_just && $urandom_range(0, 1) == 0) begin
            d_addr = 32'($urandom_range(0, 15)) << 2; d_we = 1'($urandom_range(0, 1));
            d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
            d_req = 1; d_pend = 1; d_age = 0;
         end
      end
      chk("rnd_drain_if", if_pend, 0);
      chk("rnd_drain_d", d_pend, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-ported unified memory bus between the pipeline's instruction fetch port (IF) and its load/store port (MEM stage).
- Data has fixed priority. A saturating starvation counter forces a fetch grant after STARVE_MAX consecutive data wins.
- Drives stall_if / stall_mem to the hazard logic.
- One transaction outstanding at a time; sits between the core and the memory model/controller.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables are DATA_W/8).
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_valid, dropped the cycle after.
- if_addr  in  ADDR_W  fetch address.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  load/store request; same hold rule as if_req.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_valid  out  1  one-cycle pulse: load data or store ack.
- d_rdata  out  DATA_W  load data (0 for stores).
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_be  out  DATA_W/8  bus byte enables.
- mem_gnt  in  1  bus accepted request.
- mem_rvalid  in  1  response/ack, for both reads and writes.
- mem_rdata  in  DATA_W  bus read data.
- stall_if  out  1  if_req && !if_valid (combinational).
- stall_mem  out  1  d_req && !d_valid (combinational).
- spurious_rsp  out  1  registered pulse: mem_rvalid seen outside WAIT/ISSUE.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, owner=DATA, starve_cnt=0.
  - All registered outputs 0. mem_req=0, if_valid=0, d_valid=0, both rdata=0, spurious_rsp=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Neither request: stay.
  - Else pick owner: FETCH if if_req && (!d_req || starve_cnt==STARVE_MAX); otherwise DATA.
  - Latch the owner's request into issue registers; go to ISSUE.
  - Fetch latched as: mem_we=0, mem_be=all ones, mem_addr={if_addr[ADDR_W-1:2],2'b00}, mem_wdata=0.
  - Data latched as: d_we/d_addr/d_wdata/d_be passed unchanged.
- ISSUE:
  - mem_req=1 with the latched fields, held stable until mem_gnt.
  - mem_gnt=1 and mem_rvalid=0: go to WAIT.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle: capture the response and go to RESP.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: capture mem_rdata into the owner's rdata (stores capture 0); go to RESP.
- RESP:
  - Owner's valid=1 for exactly one cycle; return to IDLE.
  - Requests in the RESP cycle are ignored (the requester still holds req).
- Latency: request in cycle N, mem_req from N+1. With gnt at N+1 and rvalid at N+2, valid pulses at N+3. Minimum 2 cycles (gnt and rvalid both at N+1, valid at N+2).
- Starvation counter:
  - On a DATA grant while if_req=1: starve_cnt++, saturating at STARVE_MAX.
  - On a FETCH grant: starve_cnt=0.
  - On a DATA grant while if_req=0: starve_cnt=0.
- spurious_rsp: mem_rvalid in IDLE or RESP pulses spurious_rsp the next cycle. Data is discarded and the state is unchanged.
- Requester dropping req mid-transaction: the transaction completes anyway, and valid still pulses.
- Reset mid-transaction: abandoned. A late mem_rvalid after reset is treated as spurious.
- Invariants:
  - At most one of if_valid/d_valid per cycle.
  - mem_req is never high outside ISSUE.
  - Issue fields are stable while mem_req && !mem_gnt.

Decomposition:
- riscv_pkg gains:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
  - typedef enum logic {ARB_OWN_DATA, ARB_OWN_FETCH} arb_owner_e.
  - Constant ARB_BE_FULL.
- No sub-module required. The starvation counter stays inline; it is 10 lines.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_1006, gnt at N+1, rvalid at N+2 with rdata=0x0000_0013 -> mem_addr=0x0000_1004, mem_we=0, mem_be=0xF; if_valid pulse at N+3 with if_rdata=0x0000_0013; stall_if=1 from N to N+2.
- Simultaneous: if_req and d_req (load 0x2000) in the same cycle -> data issued first, d_valid first; fetch issued on the next IDLE; starve_cnt=0 after the fetch grant.
- Starvation: d_req held continuously (back-to-back stores) with if_req=1, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant; counter returns to 0.
- Gnt delay: mem_gnt low for 3 cycles -> mem_req and fields stable for all 3 cycles; single completion.
- Same-cycle gnt+rvalid on a store (d_be=0x3) -> d_valid 1 cycle later, d_rdata=0, mem_be=0x3.
- rst_n asserted in WAIT, then mem_rvalid 2 cycles after release -> all outputs 0 during reset; spurious_rsp pulses once; no valid pulse.
